vector_angle: RTL
=================

VECTOR_ANGLE -- requirements
Module: vector_angle

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL be fixed constants from trig_pkg.
REQ-002 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 valid_in  input  1  request strobe; sin_in/cos_in are sampled on the edge where valid_in && ready_out.
REQ-005 sin_in  input  32  signed Q16.16 y component (1.0 = 32'h0001_0000).
REQ-006 cos_in  input  32  signed Q16.16 x component.
REQ-007 ready_out  output  1  high only when the module is idle and can accept a request.
REQ-008 angle_out  output  9  unsigned whole degrees, 0..359.
REQ-009 valid_out  output  1  one-cycle pulse qualifying angle_out.

Function
REQ-010 The module SHALL return angle_out such that (cos_in, sin_in) lies at that angle, inverting the sine/cosine tables, with result truncated toward the smaller first-quadrant angle.
REQ-011 On acceptance it SHALL register |sin_in| and |cos_in| as 31-bit unsigned magnitudes, with -2^31 saturated to 2^31-1, and register both sign bits.
REQ-012 The FSM SHALL have states IDLE, LOOKUP, COMPARE and FINISH; IDLE->LOOKUP on acceptance, LOOKUP->COMPARE always, COMPARE->LOOKUP until 7 iterations are done, then COMPARE->FINISH, and FINISH->IDLE always.
REQ-013 The search SHALL keep lo and hi (7-bit each), initialised to lo=0 and hi=90, and use mid=(lo+hi+1)>>1 for each iteration.
REQ-014 In LOOKUP, the two ROM instances SHALL be addressed with mid and 90-mid, returning sin(mid) and cos(mid) one cycle later.
REQ-015 In COMPARE, the module SHALL evaluate |y|*cos(mid) >= |x|*sin(mid) as unsigned 48-bit products with no truncation; if true it SHALL set lo=mid, otherwise hi=mid-1.
REQ-016 The search SHALL always run exactly 7 iterations, even after lo==hi; the result phi SHALL be lo, in 0..90.
REQ-017 In FINISH, the module SHALL map phi by input signs: x>=0,y>=0 gives phi; x<0,y>=0 gives 180-phi; x<0,y<0 gives 180+phi; x>=0,y<0 gives 360-phi, with 360 mapped to 0.
REQ-018 The zero vector (0,0) SHALL return 0.
REQ-019 Latency: if acceptance is at edge 0, angle_out SHALL be registered and valid_out set at edge 15, and valid_out SHALL clear at edge 16.
REQ-020 ready_out SHALL be high in IDLE only, so the earliest next acceptance is edge 16.
REQ-021 valid_in outside IDLE SHALL be ignored, and sin_in/cos_in changes after acceptance SHALL have no effect.
REQ-022 angle_out SHALL hold its last value until the next FINISH.

Reset
REQ-023 While rst_in is high, on each edge: state=IDLE, angle_out=0, valid_out=0, lo=0, hi=90, and ready_out=0.
REQ-024 Reset asserted mid-search SHALL abort the search with no valid_out pulse; ready_out SHALL be high in the first cycle after rst_in falls.

Structure
REQ-025 trig_pkg SHALL hold the state enum, ANGLE_W=9, AMP_W=32, QUARTER_DEG=90, ITERATIONS=7 and ONE_Q16=32'h0001_0000.
REQ-026 The sub-module quarter_sine_rom SHALL be used: a 7-bit address (0..90), a registered 32-bit Q16.16 sine output with 1-cycle latency, and 0 for addresses above 90.
REQ-027 vector_angle SHALL instantiate quarter_sine_rom twice, one for the sine port and one for the cosine port.

Verification
REQ-028 sin_in=32'h0000_8000, cos_in=32'h0000_DDB3 -> angle_out=30 with valid_out exactly 15 edges after acceptance.
REQ-029 The four axis vectors -> (cos,sin)=(1,0)->0, (0,1)->90, (-1,0)->180, (0,-1)->270, all in Q16.16.
REQ-030 Quadrant mirror tests -> sin=0x8000, cos=-0xDDB3 gives 150; sin=-0x8000, cos=-0xDDB3 gives 210; sin=-0x8000, cos=0xDDB3 gives 330; (0,0) gives 0; sin=cos=32'h8000_0000 gives 225.
REQ-031 Reset pulse at edge 6 of a search -> no valid_out; ready_out is high the cycle after release; a new request returns its correct angle.
REQ-032 valid_in held high with changing data -> acceptances occur every 16 edges only; each result matches the data sampled at its acceptance edge.
REQ-033 Sweep every integer degree d in 0..359, driving inputs from the table values for sin(d) and cos(d) -> angle_out=d, or d-1 where truncation applies; the bench SHALL record the mismatch count against a reference model.

Source files
------------

// File: rtl/vector_angle_pkg.sv
// Shared types and constants for the vector-angle search and its sine tables.
// The sine table is built at elaboration time from a fixed-point Taylor series.
package trig_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, COMPARE, FINISH} state_t;

    localparam int ANGLE_W     = 9;
    localparam int AMP_W       = 32;
    localparam int MAG_W       = AMP_W - 1;
    localparam int PROD_W      = 48;
    localparam int QUARTER_DEG = 90;
    localparam int ITERATIONS  = 7;
    localparam logic [AMP_W-1:0] ONE_Q16 = 32'h0001_0000;
    localparam longint PI_Q30  = 64'sd3373259426;

    // Only ever called with constant arguments: result is round(sin(deg) * 2^16).
    function automatic logic [AMP_W-1:0] sin_q16(input int deg);
        longint x, x2, term, sum;
        x    = (longint'(deg) * PI_Q30) / 64'sd180;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return AMP_W'((sum + 64'sd8192) >>> 14);
    endfunction

    function automatic logic [MAG_W-1:0] abs_sat(input logic [AMP_W-1:0] v);
        logic [AMP_W-1:0] neg;
        neg = -v;
        if (!v[AMP_W-1])
            return v[MAG_W-1:0];
        if (v == {1'b1, {MAG_W{1'b0}}})
            return {MAG_W{1'b1}};
        return neg[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/vector_angle_if.sv
// Request/response bundle for vector_angle: Q16.16 vector in, whole degrees out.
interface vector_angle_if;
    import trig_pkg::*;

    logic                valid_in;
    logic [AMP_W-1:0]    sin_in;
    logic [AMP_W-1:0]    cos_in;
    logic                ready_out;
    logic [ANGLE_W-1:0]  angle_out;
    logic                valid_out;

    modport master (output valid_in, sin_in, cos_in,
                    input  ready_out, angle_out, valid_out);
    modport slave  (input  valid_in, sin_in, cos_in,
                    output ready_out, angle_out, valid_out);
endinterface

// File: rtl/vector_angle_rom.sv
// First-quadrant sine table, 0..90 degrees in Q16.16, registered read.
module quarter_sine_rom
    import trig_pkg::*;
(
    input  logic             clk_in,
    input  logic [6:0]       addr,
    output logic [AMP_W-1:0] data
);

    logic [AMP_W-1:0] table_w [128];

    for (genvar g = 0; g < 128; g++) begin : g_tab
        if (g < QUARTER_DEG) begin : g_val
            localparam logic [AMP_W-1:0] VAL = sin_q16(g);
            assign table_w[g] = VAL;
        end else if (g == QUARTER_DEG) begin : g_one
            assign table_w[g] = ONE_Q16;
        end else begin : g_zero
            assign table_w[g] = '0;
        end
    end

    always_ff @(posedge clk_in) data <= table_w[addr];

endmodule

// File: rtl/vector_angle.sv
// Angle of a Q16.16 vector by a 7-step binary search over the first quadrant,
// comparing |y|*cos(mid) against |x|*sin(mid), then unfolding by the input signs.
module vector_angle
    import trig_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    vector_angle_if.slave bus
);

    state_t             state_q, state_d;
    logic [6:0]         lo_q, hi_q, mid;
    logic [2:0]         iter_q;
    logic [MAG_W-1:0]   mag_y_q, mag_x_q;
    logic               neg_y_q, neg_x_q;
    logic [AMP_W-1:0]   sin_mid, cos_mid;
    logic [PROD_W-1:0]  lhs, rhs;
    logic               accept, take_lo;
    logic [ANGLE_W-1:0] phi, angle_d, angle_q;
    logic               valid_q;

    assign bus.ready_out = (state_q == IDLE) && !rst_in;
    assign bus.angle_out = angle_q;
    assign bus.valid_out = valid_q;
    assign accept        = bus.valid_in && bus.ready_out;

    assign mid = 7'((8'(lo_q) + 8'(hi_q) + 8'd1) >> 1);

    quarter_sine_rom u_sin_rom (.clk_in(clk_in), .addr(mid), .data(sin_mid));
    quarter_sine_rom u_cos_rom (.clk_in(clk_in), .addr(7'(QUARTER_DEG) - mid), .data(cos_mid));

    // tan(phi) >= tan(mid) without division; magnitudes are at most 31 x 17 bits.
    assign lhs     = {17'b0, mag_y_q} * {16'b0, cos_mid};
    assign rhs     = {17'b0, mag_x_q} * {16'b0, sin_mid};
    assign take_lo = lhs >= rhs;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP:  state_d = COMPARE;
            COMPARE: state_d = (iter_q == 3'(ITERATIONS - 1)) ? FINISH : LOOKUP;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phi     = ANGLE_W'(lo_q);
        angle_d = phi;
        if (mag_y_q == '0 && mag_x_q == '0) begin
            angle_d = '0;
        end else begin
            unique case ({neg_x_q, neg_y_q})
                2'b00:   angle_d = phi;
                2'b10:   angle_d = 9'd180 - phi;
                2'b11:   angle_d = 9'd180 + phi;
                default: angle_d = (phi == '0) ? '0 : 9'd360 - phi;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lo_q    <= '0;
            hi_q    <= 7'(QUARTER_DEG);
            iter_q  <= '0;
            angle_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    mag_y_q <= abs_sat(bus.sin_in);
                    mag_x_q <= abs_sat(bus.cos_in);
                    neg_y_q <= bus.sin_in[AMP_W-1];
                    neg_x_q <= bus.cos_in[AMP_W-1];
                    lo_q    <= '0;
                    hi_q    <= 7'(QUARTER_DEG);
                    iter_q  <= '0;
                end
                COMPARE: begin
                    if (take_lo) lo_q <= mid;
                    else         hi_q <= mid - 7'd1;
                    iter_q <= iter_q + 3'd1;
                end
                FINISH: begin
                    angle_q <= angle_d;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
